// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory interface controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   localparam int          DMEM_TIMEOUT_DEF = 64;
   localparam logic [31:0] DMEM_WORD_MASK   = 32'hFFFF_FFFC;

   // Counter width able to hold TIMEOUT_CYCLES-1; never narrower than one bit.
   function automatic int dmem_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Response timeout counter: synchronous clear, count enable, terminal count at TIMEOUT_CYCLES-1.
module dmem_timeout_ctr
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int W = dmem_cnt_w(TIMEOUT_CYCLES);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) cnt <= '0;
      else if (en)      cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dmem_if_ctrl.sv
// M-stage data-memory interface: one outstanding valid/ready request, response wait with timeout,
// and a stall to the hazard unit. Optional DMEM_MISALIGN_CHK_EN rejects unaligned accesses.
module dmem_if_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [31:0]       ALUO_M,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] DataR_M,
   output logic              mem_stall,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_rsp_valid,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_err
`ifdef DMEM_MISALIGN_CHK_EN
   ,
   output logic              misalign_err
`endif
);

   dmem_state_t state, state_nxt;
   logic        mem_req, misalign, tmo_tc;

   assign mem_req = MemReadM | MemWriteM;

`ifdef DMEM_MISALIGN_CHK_EN
   assign misalign = (ALUO_M[1:0] != 2'b00);
`else
   // Low address bits are dropped by the word mask; keep them visibly unused.
   logic addr_lo_unused;
   assign addr_lo_unused = ^ALUO_M[1:0];
   assign misalign       = 1'b0;
`endif

   dmem_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
      .clk   (clk),
      .reset (reset),
      .clr   (state == REQ && bus_req_ready),
      .en    (state == RESP),
      .tc    (tmo_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (mem_req)                  state_nxt = misalign ? DONE : REQ;
         REQ:  if (bus_req_ready)            state_nxt = RESP;
         RESP: if (bus_rsp_valid || tmo_tc)  state_nxt = DONE;
         DONE:                               state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_stall     = (state == IDLE && mem_req) || state == REQ || state == RESP;
      bus_req_valid = (state == REQ);
   end

   // Request registers are captured once in IDLE and held untouched until the next request.
   always_ff @(posedge clk) begin
      if (reset) begin
         DataR_M      <= '0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_err      <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
         misalign_err <= 1'b0;
`endif
      end else begin
         bus_err      <= 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
         misalign_err <= 1'b0;
`endif
         case (state)
            IDLE: if (mem_req) begin
               bus_addr  <= ADDR_W'(ALUO_M & DMEM_WORD_MASK);
               bus_we    <= MemWriteM;
               bus_wdata <= WriteDataM;
`ifdef DMEM_MISALIGN_CHK_EN
               if (misalign) begin
                  DataR_M      <= '0;
                  misalign_err <= 1'b1;
               end
`endif
            end
            // A response in the terminal-count cycle still completes without error.
            RESP: if (bus_rsp_valid) begin
               if (!bus_we) DataR_M <= bus_rdata;
            end else if (tmo_tc) begin
               DataR_M <= '0;
               bus_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_if_ctrl.sv
// Self-checking bench for dmem_if_ctrl: per-transaction timeline model plus randomized traffic.
module tb_dmem_if_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [31:0] ALUO_M, WriteDataM, DataR_M;
   logic        mem_stall, bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_rsp_valid, bus_err;
`ifdef DMEM_MISALIGN_CHK_EN
   logic        misalign_err;
   logic        e_mis = 1'b0;
`endif

   dmem_if_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .MemReadM      (MemReadM),
      .MemWriteM     (MemWriteM),
      .ALUO_M        (ALUO_M),
      .WriteDataM    (WriteDataM),
      .DataR_M       (DataR_M),
      .mem_stall     (mem_stall),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_we        (bus_we),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rdata     (bus_rdata),
      .bus_err       (bus_err)
`ifdef DMEM_MISALIGN_CHK_EN
      ,
      .misalign_err  (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   int          stall_cnt = 0, err_cnt = 0;
   logic        chk_en = 1'b0;
   logic        e_stall, e_vld, e_we, e_err;
   logic [31:0] e_addr, e_wdata, e_data;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
      end
   endtask

   // Single compare point, mid-cycle, against the expectations set for this cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_stall", 32'(mem_stall), 32'(e_stall));
         chk("bus_req_valid", 32'(bus_req_valid), 32'(e_vld));
         if (e_vld) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_wdata", bus_wdata, e_wdata);
         end
         chk("bus_err", 32'(bus_err), 32'(e_err));
         chk("DataR_M", DataR_M, e_data);
`ifdef DMEM_MISALIGN_CHK_EN
         chk("misalign_err", 32'(misalign_err), 32'(e_mis));
`endif
         stall_cnt += int'(mem_stall);
         err_cnt   += int'(bus_err);
      end
   end

   // One M-stage instruction: r = ready-low cycles in REQ, lat = RESP cycles before the
   // response (lat >= TO means the response never comes).
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int r, input int lat);
      logic        mem, mis, tmo;
      int          s, respc, n;
      logic [31:0] new_d;
      mem = rd | wr;
      mis = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
      mis = mem && (a[1:0] != 2'b00);
`endif
      s     = 2 + r;
      tmo   = (lat >= TO);
      respc = tmo ? TO : lat + 1;
      n     = !mem ? 1 : (mis ? 2 : s + respc + 1);
      new_d = (mis || tmo) ? 32'h0 : (wr ? e_data : rdat);
      for (int k = 0; k < n; k++) begin
         logic in_req, in_resp, last;
         @(posedge clk); #1;
         in_req  = mem && !mis && k >= 1 && k <= 1 + r;
         in_resp = mem && !mis && k >= s && k < s + respc;
         last    = mem && (k == n - 1);
         MemReadM      = rd;
         MemWriteM     = wr;
         ALUO_M        = a;
         WriteDataM    = wd;
         bus_req_ready = in_req ? (k == 1 + r) : 1'($urandom_range(0, 1));
         bus_rsp_valid = in_resp ? (!tmo && k == s + lat)
                                 : (in_req ? 1'b0 : ($urandom_range(0, 3) == 0));
         bus_rdata     = in_resp ? rdat : $urandom;
         e_stall = mem && (k < n - 1);
         e_vld   = in_req;
         e_addr  = a & 32'hFFFF_FFFC;
         e_we    = wr;
         e_wdata = wd;
         e_err   = last && !mis && tmo;
`ifdef DMEM_MISALIGN_CHK_EN
         e_mis   = last && mis;
`endif
         if (last) e_data = new_d;
      end
      @(negedge clk); #1;
   endtask

   initial begin
      int st0, er0;
      logic [31:0] a;
      reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; ALUO_M = '0; WriteDataM = '0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
      e_stall = 1'b0; e_vld = 1'b0; e_we = 1'b0; e_err = 1'b0;
      e_addr = '0; e_wdata = '0; e_data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_DataR_M", DataR_M, 32'h0);
      chk("rst_bus_req_valid", 32'(bus_req_valid), 32'h0);
      chk("rst_bus_we", 32'(bus_we), 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      chk("rst_bus_err", 32'(bus_err), 32'h0);
      chk("rst_mem_stall", 32'(mem_stall), 32'h0);
      chk_en = 1'b1;

      // Zero-wait load: three stall cycles, data visible in DONE.
      st0 = stall_cnt;
      run_txn(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
      chk("zw_stall_cycles", 32'(stall_cnt - st0), 32'd3);
      chk("zw_data", DataR_M, 32'hDEADBEEF);

      // Store with five cycles of backpressure; load data register untouched.
      run_txn(1'b0, 1'b1, 32'h204, 32'h12345678, 32'h0BAD0BAD, 5, 1);
      chk("st_data_kept", DataR_M, 32'hDEADBEEF);

      // Timeout: 1 detect + 1 REQ + 8 RESP stall cycles, one error pulse, data cleared.
      st0 = stall_cnt; er0 = err_cnt;
      run_txn(1'b1, 1'b0, 32'h40, 32'h0, 32'h5A5A5A5A, 0, TO + 3);
      chk("tmo_stall_cycles", 32'(stall_cnt - st0), 32'd10);
      chk("tmo_err_pulses", 32'(err_cnt - er0), 32'd1);
      chk("tmo_data", DataR_M, 32'h0);
      run_txn(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Response on the terminal-count cycle wins over the timeout.
      er0 = err_cnt;
      run_txn(1'b1, 1'b0, 32'h80, 32'h0, 32'h11112222, 1, TO - 1);
      chk("edge_data", DataR_M, 32'h11112222);
      chk("edge_no_err", 32'(err_cnt - er0), 32'd0);

      // Back-to-back load then store.
      run_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h01020304, 0, 0);
      run_txn(1'b0, 1'b1, 32'h14, 32'hCAFE0001, 32'h0, 0, 0);
      chk("b2b_data", DataR_M, 32'h01020304);

      // Misaligned read.
      run_txn(1'b1, 1'b0, 32'h103, 32'h0, 32'hCAFEF00D, 0, 0);
`ifdef DMEM_MISALIGN_CHK_EN
      chk("mis_data", DataR_M, 32'h0);
`else
      chk("mis_data", DataR_M, 32'hCAFEF00D);
`endif

      // Reset during RESP, then a late response that must be dropped.
      @(posedge clk); #1;
      MemReadM = 1'b1; MemWriteM = 1'b0; ALUO_M = 32'h300; WriteDataM = 32'h0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      e_stall = 1'b1; e_vld = 1'b0; e_err = 1'b0;
      @(posedge clk); #1;
      bus_req_ready = 1'b1; e_vld = 1'b1; e_addr = 32'h300; e_we = 1'b0; e_wdata = 32'h0;
      @(posedge clk); #1;
      bus_req_ready = 1'b0; e_vld = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; chk_en = 1'b1; MemReadM = 1'b0;
      bus_rsp_valid = 1'b1; bus_rdata = 32'hAAAA5555;
      e_stall = 1'b0; e_vld = 1'b0; e_err = 1'b0; e_data = 32'h0;
      @(posedge clk); #1;
      bus_rsp_valid = 1'b0;
      @(negedge clk); #1;
      chk("rst_mid_data", DataR_M, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         int ty, p, r, lat;
         logic rd, wr;
         ty = $urandom_range(0, 5);
         rd = (ty == 1 || ty == 2 || ty == 5);
         wr = (ty == 3 || ty == 4 || ty == 5);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         r  = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 3);
         p  = $urandom_range(0, 9);
         lat = (p < 6) ? $urandom_range(0, 3) : (p == 6) ? TO - 1 : (p == 7) ? TO - 2 : TO + 1;
         run_txn(rd, wr, a, $urandom, $urandom, r, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
